// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory arbiter: FSM states, grant
// identifiers and the default acknowledge timeout.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    IF_ACC,
    DM_ACC
  } arb_state_e;

  typedef enum logic {
    GNT_IF,
    GNT_DM
  } grant_e;

  localparam int TIMEOUT_DEFAULT = 255;

endpackage

// File: rtl/arb_timeout_cnt.sv
// Wait-cycle counter for an outstanding memory access; tc flags the cycle
// whose missing acknowledge brings the count up to TIMEOUT.
module arb_timeout_cnt #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tc = (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between the fetch and data ports: one access in
// flight, alternating priority on conflicts, sticky timeout error.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_if_req,
  input  logic [31:0] i_if_addr,
  output logic [31:0] o_if_rdata,
  output logic        o_if_valid,
  input  logic        i_dm_req,
  input  logic        i_dm_we,
  input  logic [31:0] i_dm_addr,
  input  logic [31:0] i_dm_wdata,
  output logic [31:0] o_dm_rdata,
  output logic        o_dm_valid,
  output logic        o_stall_f,
  output logic        o_stall_m,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [31:0] o_mem_addr,
  output logic [31:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [31:0] i_mem_rdata,
  output logic        o_bus_err
);

  arb_state_e state;
  grant_e     last_grant;
  logic       if_pend, dm_pend, pick_dm;
  logic       cnt_tc, done;

  // A port whose valid is pulsing this cycle has been served; its still-high
  // request must not trigger a second grant.
  assign if_pend = i_if_req & ~o_if_valid;
  assign dm_pend = i_dm_req & ~o_dm_valid;
  assign pick_dm = dm_pend & (~if_pend | (last_grant == GNT_IF));

  assign o_stall_f = i_if_req & ~o_if_valid;
  assign o_stall_m = i_dm_req & ~o_dm_valid;

  assign done = i_mem_ack | cnt_tc;

  arb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_tmo (
    .clk(clk),
    .rst(rst),
    .clr(state == IDLE),
    .en ((state != IDLE) & ~i_mem_ack),
    .tc (cnt_tc)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      last_grant  <= GNT_IF;
      o_mem_req   <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= '0;
      o_if_valid  <= 1'b0;
      o_dm_valid  <= 1'b0;
      o_if_rdata  <= '0;
      o_dm_rdata  <= '0;
      o_bus_err   <= 1'b0;
    end else begin
      o_if_valid <= 1'b0;
      o_dm_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_dm) begin
            state       <= DM_ACC;
            last_grant  <= GNT_DM;
            o_mem_req   <= 1'b1;
            o_mem_we    <= i_dm_we;
            o_mem_addr  <= i_dm_addr;
            o_mem_wdata <= i_dm_wdata;
          end else if (if_pend) begin
            state       <= IF_ACC;
            last_grant  <= GNT_IF;
            o_mem_req   <= 1'b1;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= i_if_addr;
            o_mem_wdata <= '0;
          end
        end
        IF_ACC, DM_ACC: begin
          if (done) begin
            state     <= IDLE;
            o_mem_req <= 1'b0;
            if (!i_mem_ack) o_bus_err <= 1'b1;
            // Aborted accesses and stores both return zero data.
            if (state == IF_ACC) begin
              o_if_valid <= 1'b1;
              o_if_rdata <= i_mem_ack ? i_mem_rdata : '0;
            end else begin
              o_dm_valid <= 1'b1;
              o_dm_rdata <= (i_mem_ack && !o_mem_we) ? i_mem_rdata : '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: maximum wait cycles for memory acknowledge before an access is aborted.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 i_if_req  input  1  fetch port request; held high until o_if_valid.
REQ-005 i_if_addr  input  32  fetch address (PC); stable while i_if_req is high.
REQ-006 o_if_rdata  output  32  fetched instruction; registered, valid with o_if_valid.
REQ-007 o_if_valid  output  1  one-cycle completion pulse for the fetch port.
REQ-008 i_dm_req  input  1  data port request (load or store); held high until o_dm_valid.
REQ-009 i_dm_we  input  1  data port write enable (1 = store).
REQ-010 i_dm_addr  input  32  data address (ALU result, M stage).
REQ-011 i_dm_wdata  input  32  store data.
REQ-012 o_dm_rdata  output  32  load data; registered, valid with o_dm_valid.
REQ-013 o_dm_valid  output  1  one-cycle completion pulse for the data port.
REQ-014 o_stall_f  output  1  stall request to the hazard unit for fetch: i_if_req & ~o_if_valid.
REQ-015 o_stall_m  output  1  stall request for the memory stage: i_dm_req & ~o_dm_valid.
REQ-016 o_mem_req, o_mem_we  output  1 each  single-port memory request and write enable.
REQ-017 o_mem_addr, o_mem_wdata  output  32 each  memory address and write data.
REQ-018 i_mem_ack  input  1  memory completes the access in this cycle.
REQ-019 i_mem_rdata  input  32  read data, valid in the i_mem_ack cycle.
REQ-020 o_bus_err  output  1  sticky timeout flag.

Function
REQ-021 FSM states: IDLE, IF_ACC, DM_ACC; one access outstanding at a time.
REQ-022 IDLE, only one request pending: grant it; next state IF_ACC or DM_ACC.
REQ-023 IDLE, both pending: grant the port not granted last (last_grant register); last_grant resets to IF, so the data port wins the first conflict.
REQ-024 On grant, latch addr/we/wdata from the granted port; o_mem_req asserts the cycle after the request is seen in IDLE and holds with stable outputs until i_mem_ack.
REQ-025 Fetch accesses always drive o_mem_we = 0 and o_mem_wdata = 0.
REQ-026 i_mem_ack in cycle M: o_mem_req deasserts in M+1; the granted port's valid pulses in M+1 with rdata = i_mem_rdata captured at M (stores return 0); state returns to IDLE in M+1.
REQ-027 Minimum access latency is 2 cycles from request to valid (ack in the first o_mem_req cycle); back-to-back grants are possible with no idle bubble beyond the IDLE evaluation cycle.
REQ-028 The timeout counter clears on entry to an ACC state and increments each cycle without ack; when it reaches TIMEOUT, drop o_mem_req, set o_bus_err, pulse the granted valid with rdata 0, and return to IDLE.
REQ-029 i_mem_ack in IDLE is ignored.
REQ-030 A request dropped mid-access does not abort it; the access completes and valid still pulses.
REQ-031 o_if_rdata/o_dm_rdata hold their last value between valid pulses.

Reset
REQ-032 rst low forces IDLE, last_grant = IF, counter = 0, o_bus_err = 0, o_mem_req = 0, o_mem_we = 0, both valids = 0, all data/address outputs = 0, immediately and regardless of the clock.
REQ-033 Reset asserted mid-access abandons the access; no valid pulse follows reset release; the first grant after release follows REQ-022/023.

Structure
REQ-034 Shared package mem_arb_pkg holds the state enum, the grant enum (GNT_IF, GNT_DM) and TIMEOUT_DEFAULT = 255.
REQ-035 One sub-module, arb_timeout_cnt (clear, enable, terminal-count output, width $clog2(TIMEOUT+1)).

Verification
REQ-036 Fetch at 0x0000_0010, ack after 3 cycles with rdata 0x0050_0093 -> o_if_valid one cycle later with 0x0050_0093; o_stall_f high until then.
REQ-037 Both requests at reset release (dm store addr 0x100, wdata 0xDEAD_BEEF) -> data granted first with o_mem_we = 1, fetch granted next.
REQ-038 Both requesters held continuously, ack every cycle -> grants alternate DM, IF, DM, IF; neither port starves.
REQ-039 TIMEOUT = 4, no ack -> o_mem_req drops after 4 wait cycles, o_bus_err = 1 sticky, valid pulses with rdata 0.
REQ-040 rst pulsed low during DM_ACC -> all outputs 0 immediately, no o_dm_valid after release, a new request served normally.
